// File: rtl/uart_pkg.sv
// Purpose : shared constants and types for the UART transmit controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // CON register bit positions
    localparam int CON_EN_BIT     = 0;
    localparam int CON_TXIE_BIT   = 1;
    localparam int CON_DIV_EN_BIT = 4;
    localparam int CON_TXDONE_BIT = 8;
    localparam int CON_BUSY_BIT   = 9;
    localparam int CON_RXLVL_BIT  = 15;

    // Default prescale factor used when CON.DIV_EN is set (legal 1..15)
    localparam int unsigned DIV_SEL_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Purpose : turns the external baud-source signal into one-cycle bit boundaries.
// Latency : source edge reaches src_tick 2 cycles later; bit_tick is combinational on the Nth src_tick.
// Backpressure: none; restart clears the counters and reloads BAUD/DIV settings.
//
// Ports:
//   sys_clk, sys_rstn  clock and synchronous active-low reset
//   uart_baud_clk      baud-source level, sampled as data
//   restart            clear counters and reload settings (frame start)
//   baud_val, div_en   live BAUD register and CON.DIV_EN
//   bit_tick           one-cycle pulse at the end of each bit period
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_SEL = DIV_SEL_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rstn,
    input  logic        uart_baud_clk,
    input  logic        restart,
    input  logic [15:0] baud_val,
    input  logic        div_en,
    output logic        bit_tick
);

    localparam logic [3:0] DIV_W = 4'(DIV_SEL);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        sync3_q, sync3_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [15:0] baud_lat_q, baud_lat_d;
    logic [3:0]  div_lat_q, div_lat_d;
    logic        src_tick;
    logic        pre_last;
    logic [3:0]  div_now;

    always_comb begin
        sync1_d    = uart_baud_clk;
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        src_tick   = sync2_q & ~sync3_q;
        div_now    = div_en ? DIV_W : 4'd1;
        // 5-bit compare so a divisor of 15 cannot wrap and a stray 0 acts as 1
        pre_last   = ({1'b0, pre_cnt_q} + 5'd1) >= {1'b0, div_lat_q};
        pre_cnt_d  = pre_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        baud_lat_d = baud_lat_q;
        div_lat_d  = div_lat_q;
        bit_tick   = 1'b0;

        if (restart) begin
            pre_cnt_d  = 4'd0;
            bit_cnt_d  = 16'd0;
            baud_lat_d = baud_val;
            div_lat_d  = div_now;
        end else if (src_tick) begin
            if (pre_last) begin
                pre_cnt_d = 4'd0;
                if (bit_cnt_q >= baud_lat_q) begin
                    // Bit boundary: settings written mid-bit apply from here on
                    bit_cnt_d  = 16'd0;
                    bit_tick   = 1'b1;
                    baud_lat_d = baud_val;
                    div_lat_d  = div_now;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end else begin
                pre_cnt_d = pre_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            pre_cnt_q  <= 4'd0;
            bit_cnt_q  <= 16'd0;
            baud_lat_q <= 16'd0;
            div_lat_q  <= 4'd1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            pre_cnt_q  <= pre_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_lat_q <= baud_lat_d;
            div_lat_q  <= div_lat_d;
        end
    end

endmodule

// File: rtl/uart_ctrl_top.sv
// Purpose : register-programmed 8N1 UART transmitter with CON/BAUD/TXBUF and a level interrupt.
// Latency : accepted TXBUF write drives the start bit on the next edge; readbacks show writes one cycle later.
// Backpressure: TXBUF writes while BUSY are dropped; software polls CON.BUSY or waits for TXDONE.
//
// Ports:
//   sys_clk, sys_rstn                       clock and synchronous active-low reset
//   uart_baud_clk                           baud-source level (data, not a clock)
//   uart_con_wr/uart_baud_wr/uart_txbuf_wr  one-cycle write strobes, data on icb_wdat
//   uart_rx                                 serial input, reported as CON.RXLVL only
//   uart_con/uart_baud/uart_txbuf           register readbacks
//   uart_tx, uart_en, uart_int              serial line, CON.EN, TXDONE & TXIE
module uart_ctrl_top
    import uart_pkg::*;
#(
    parameter int unsigned DIV_SEL   = DIV_SEL_DEF,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rstn,
    input  logic        uart_baud_clk,
    input  logic        uart_baud_wr,
    input  logic        uart_con_wr,
    input  logic        uart_txbuf_wr,
    input  logic [15:0] icb_wdat,
    input  logic        uart_rx,
    output logic [15:0] uart_con,
    output logic [15:0] uart_baud,
    output logic [15:0] uart_txbuf,
    output logic        uart_tx,
    output logic        uart_en,
    output logic        uart_int
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e   state_q, state_d;
    logic        en_q, en_d;
    logic        txie_q, txie_d;
    logic        div_en_q, div_en_d;
    logic        txdone_q, txdone_d;
    logic [15:0] baud_q, baud_d;
    logic [7:0]  txbuf_q, txbuf_d;
    logic        rx_s1_q, rx_s1_d;
    logic        rx_s2_q, rx_s2_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        int_q, int_d;

    logic        busy;
    logic        accept;
    logic        bit_tick;
    logic        txdone_set;
    logic        txdone_clr;

    uart_baud_gen #(
        .DIV_SEL (DIV_SEL)
    ) u_baud_gen (
        .sys_clk       (sys_clk),
        .sys_rstn      (sys_rstn),
        .uart_baud_clk (uart_baud_clk),
        .restart       (accept),
        .baud_val      (baud_q),
        .div_en        (div_en_q),
        .bit_tick      (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        txie_d     = txie_q;
        div_en_d   = div_en_q;
        baud_d     = baud_q;
        txbuf_d    = txbuf_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rx_s1_d    = uart_rx;
        rx_s2_d    = rx_s1_q;
        txdone_set = 1'b0;

        busy   = (state_q != ST_IDLE);
        accept = uart_txbuf_wr & en_q & ~busy;

        if (uart_con_wr) begin
            en_d     = icb_wdat[CON_EN_BIT];
            txie_d   = icb_wdat[CON_TXIE_BIT];
            div_en_d = icb_wdat[CON_DIV_EN_BIT];
        end
        if (uart_baud_wr) begin
            baud_d = icb_wdat;
        end
        // The byte is kept even with EN=0 so software can preload it
        if (uart_txbuf_wr && !busy) begin
            txbuf_d = icb_wdat[7:0];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    shift_d   = icb_wdat[7:0];
                    bit_idx_d = 3'd0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    state_d    = ST_IDLE;
                    tx_d       = 1'b1;
                    txdone_set = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Disabling takes effect on the same edge as the CON write and
        // abandons the frame without reporting completion
        if (!en_d) begin
            state_d    = ST_IDLE;
            tx_d       = 1'b1;
            txdone_set = 1'b0;
        end

        // Write-1-to-clear, but a completion in the same cycle wins
        txdone_clr = uart_con_wr & icb_wdat[CON_TXDONE_BIT];
        txdone_d   = txdone_set | (txdone_q & ~txdone_clr);
        int_d      = txdone_d & txie_d;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            txie_q    <= 1'b0;
            div_en_q  <= 1'b0;
            txdone_q  <= 1'b0;
            baud_q    <= 16'd0;
            txbuf_q   <= 8'd0;
            rx_s1_q   <= 1'b0;
            rx_s2_q   <= 1'b0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            int_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            txie_q    <= txie_d;
            div_en_q  <= div_en_d;
            txdone_q  <= txdone_d;
            baud_q    <= baud_d;
            txbuf_q   <= txbuf_d;
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            int_q     <= int_d;
        end
    end

    always_comb begin
        uart_con                 = 16'd0;
        uart_con[CON_EN_BIT]     = en_q;
        uart_con[CON_TXIE_BIT]   = txie_q;
        uart_con[CON_DIV_EN_BIT] = div_en_q;
        uart_con[CON_TXDONE_BIT] = txdone_q;
        uart_con[CON_BUSY_BIT]   = (state_q != ST_IDLE);
        uart_con[CON_RXLVL_BIT]  = rx_s2_q;
    end

    assign uart_baud  = baud_q;
    assign uart_txbuf = {8'h00, txbuf_q};
    assign uart_tx    = tx_q;
    assign uart_en    = en_q;
    assign uart_int   = int_q;

endmodule

// File: tb/tb_uart_ctrl_top.sv
`timescale 1ns/1ps
module tb_uart_ctrl_top;

    logic        sys_clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        uart_baud_clk = 1'b0;
    logic        uart_baud_wr = 1'b0;
    logic        uart_con_wr = 1'b0;
    logic        uart_txbuf_wr = 1'b0;
    logic [15:0] icb_wdat = 16'h0000;
    logic        uart_rx = 1'b1;
    logic [15:0] uart_con;
    logic [15:0] uart_baud;
    logic [15:0] uart_txbuf;
    logic        uart_tx;
    logic        uart_en;
    logic        uart_int;

    int n_tests = 0;
    int n_fail  = 0;

    // sys_clk 50 MHz, baud source at half that rate (the fastest legal ratio)
    always #10 sys_clk = ~sys_clk;
    always #20 uart_baud_clk = ~uart_baud_clk;

    uart_ctrl_top dut (
        .sys_clk       (sys_clk),
        .sys_rstn      (sys_rstn),
        .uart_baud_clk (uart_baud_clk),
        .uart_baud_wr  (uart_baud_wr),
        .uart_con_wr   (uart_con_wr),
        .uart_txbuf_wr (uart_txbuf_wr),
        .icb_wdat      (icb_wdat),
        .uart_rx       (uart_rx),
        .uart_con      (uart_con),
        .uart_baud     (uart_baud),
        .uart_txbuf    (uart_txbuf),
        .uart_tx       (uart_tx),
        .uart_en       (uart_en),
        .uart_int      (uart_int)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All write tasks are entered on a negedge and return on the next negedge
    task automatic wr_con(input logic [15:0] v);
        uart_con_wr = 1'b1; icb_wdat = v;
        @(negedge sys_clk);
        uart_con_wr = 1'b0;
    endtask

    task automatic wr_baud(input logic [15:0] v);
        uart_baud_wr = 1'b1; icb_wdat = v;
        @(negedge sys_clk);
        uart_baud_wr = 1'b0;
    endtask

    task automatic wr_txbuf(input logic [7:0] b);
        uart_txbuf_wr = 1'b1; icb_wdat = {8'h00, b};
        @(negedge sys_clk);
        uart_txbuf_wr = 1'b0;
    endtask

    // Bit period here is 12 src_ticks = 24 sys cycles; sample each bit mid-period.
    // Returns on the negedge where BUSY is first seen low.
    task automatic send_frame(input logic [7:0] b, input int inj,
                              output logic [9:0] bits, output int len);
        bit done;
        done = 1'b0;
        bits = '1;
        len  = 0;
        wr_txbuf(b);
        check_val("start_low", {31'd0, uart_tx}, 32'd0);
        check_val("start_busy", {31'd0, uart_con[9]}, 32'd1);
        for (int c = 1; c < 400 && !done; c++) begin
            @(negedge sys_clk);
            if (inj > 0 && c == inj) begin
                uart_txbuf_wr = 1'b1; icb_wdat = 16'h00A5;
            end else if (inj > 0 && c == inj + 1) begin
                uart_txbuf_wr = 1'b0;
            end
            if (c >= 11 && ((c - 11) % 24) == 0 && ((c - 11) / 24) < 10)
                bits[(c - 11) / 24] = uart_tx;
            if (!uart_con[9]) begin
                done = 1'b1;
                len  = c;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        int         len;

        // Reset held 30 cycles
        repeat (30) @(negedge sys_clk);
        check_val("rst_con", {16'd0, uart_con}, 32'h0);
        check_val("rst_baud", {16'd0, uart_baud}, 32'h0);
        check_val("rst_txbuf", {16'd0, uart_txbuf}, 32'h0);
        check_val("rst_tx", {31'd0, uart_tx}, 32'd1);
        check_val("rst_int", {31'd0, uart_int}, 32'd0);
        check_val("rst_en", {31'd0, uart_en}, 32'd0);
        sys_rstn = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Register write / readback (RXLVL reflects uart_rx=1)
        wr_baud(16'h0003);
        wr_con(16'h0011);
        check_val("rd_baud", {16'd0, uart_baud}, 32'h0003);
        check_val("rd_con", {16'd0, uart_con}, 32'h8011);
        check_val("rd_en", {31'd0, uart_en}, 32'd1);

        // Frame 0x6C: 0,0,0,1,1,0,1,1,0,1 on the line
        send_frame(8'h6C, 0, bits, len);
        check_val("f1_bits", {22'd0, bits}, 32'h2D8);
        check_val("f1_len", {31'd0, (len == 239 || len == 240)}, 32'd1);
        check_val("f1_con", {16'd0, uart_con}, 32'h8111);
        check_val("f1_int", {31'd0, uart_int}, 32'd0);
        check_val("f1_idle", {31'd0, uart_tx}, 32'd1);
        check_val("f1_txbuf", {16'd0, uart_txbuf}, 32'h006C);

        // Clear TXDONE, enable interrupt; busy-guard write of A5 mid-frame
        wr_con(16'h0113);
        check_val("ie_con", {16'd0, uart_con}, 32'h8013);
        check_val("ie_int0", {31'd0, uart_int}, 32'd0);
        send_frame(8'h6C, 60, bits, len);
        check_val("f2_bits", {22'd0, bits}, 32'h2D8);
        check_val("f2_len", {31'd0, (len == 239 || len == 240)}, 32'd1);
        check_val("f2_txbuf", {16'd0, uart_txbuf}, 32'h006C);
        check_val("f2_int", {31'd0, uart_int}, 32'd1);
        check_val("f2_con", {16'd0, uart_con}, 32'h8113);

        // Back-to-back write in the cycle after the stop bit ends
        send_frame(8'h81, 0, bits, len);
        check_val("f3_bits", {22'd0, bits}, 32'h302);
        check_val("f3_txbuf", {16'd0, uart_txbuf}, 32'h0081);
        wr_con(16'h0113);
        check_val("clr_con", {16'd0, uart_con}, 32'h8013);
        check_val("clr_int", {31'd0, uart_int}, 32'd0);

        // EN=0: byte stored, no frame
        wr_con(16'h0010);
        check_val("dis_en", {31'd0, uart_en}, 32'd0);
        wr_txbuf(8'h3C);
        check_val("dis_txbuf", {16'd0, uart_txbuf}, 32'h003C);
        check_val("dis_con", {16'd0, uart_con}, 32'h8010);
        repeat (50) @(negedge sys_clk);
        check_val("dis_tx", {31'd0, uart_tx}, 32'd1);

        // EN cleared mid-frame
        wr_con(16'h0011);
        wr_txbuf(8'h55);
        repeat (10) @(negedge sys_clk);
        check_val("ab_pre_tx", {31'd0, uart_tx}, 32'd0);
        wr_con(16'h0010);
        check_val("ab_tx", {31'd0, uart_tx}, 32'd1);
        check_val("ab_con", {16'd0, uart_con}, 32'h8010);
        repeat (300) @(negedge sys_clk);
        check_val("ab_late_con", {16'd0, uart_con}, 32'h8010);
        check_val("ab_late_tx", {31'd0, uart_tx}, 32'd1);
        check_val("ab_txbuf", {16'd0, uart_txbuf}, 32'h0055);

        // Reset mid-frame
        wr_con(16'h0011);
        wr_txbuf(8'h00);
        repeat (10) @(negedge sys_clk);
        check_val("mr_pre_tx", {31'd0, uart_tx}, 32'd0);
        sys_rstn = 1'b0;
        @(negedge sys_clk);
        check_val("mr_tx", {31'd0, uart_tx}, 32'd1);
        check_val("mr_con", {16'd0, uart_con}, 32'h0);
        check_val("mr_baud", {16'd0, uart_baud}, 32'h0);
        check_val("mr_txbuf", {16'd0, uart_txbuf}, 32'h0);
        check_val("mr_int", {31'd0, uart_int}, 32'd0);
        sys_rstn = 1'b1;
        repeat (60) @(negedge sys_clk);
        check_val("mr_post_tx", {31'd0, uart_tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_ctrl_top.md
Name: uart_ctrl_top

Overview:
- Register-programmed UART transmitter block on the on-chip bus (ICB) write path.
- Holds three 16-bit control/status registers (CON, BAUD, TXBUF) and serialises a byte written to TXBUF as an 8N1 frame on uart_tx.
- Bit timing comes from an external baud-source signal, counted in the sys_clk domain.
- Raises uart_int when a frame completes.

Parameters:
- DIV_SEL, 3, prescale factor applied when CON.DIV_EN=1 (legal 1..15).
- DATA_BITS, 8, data bits per frame (fixed 8N1 framing; other values not required).

Ports:
- sys_clk  in  1  sole clock; every flop on its rising edge.
- sys_rstn  in  1  reset, synchronous, active-low.
- uart_baud_clk  in  1  baud-source signal; sampled as data, never used as a clock.
- uart_baud_wr  in  1  one-cycle write strobe for BAUD.
- uart_con_wr  in  1  one-cycle write strobe for CON.
- uart_txbuf_wr  in  1  one-cycle write strobe for TXBUF.
- icb_wdat  in  16  write data, sampled with a strobe.
- uart_rx  in  1  serial input; status only, no receiver.
- uart_con  out  16  CON readback.
- uart_baud  out  16  BAUD readback.
- uart_txbuf  out  16  {8'h00, last accepted byte}.
- uart_tx  out  1  serial output, idle high.
- uart_en  out  1  equals CON[0].
- uart_int  out  1  interrupt, level.

Behaviour:
- Clocking and reset:
  - One clock domain. Design decision: uart_baud_clk frequency must be <= sys_clk/2.
  - Synchronous active-low reset clears all registers to 0 and forces uart_tx=1, uart_int=0, FSM to IDLE.
  - Reset asserted mid-frame aborts the frame immediately; uart_tx=1 on the next edge.
- CON bit map:
  - [0] EN, RW.
  - [1] TXIE, RW.
  - [4] DIV_EN, RW.
  - [8] TXDONE, sticky; set at end of stop bit; write 1 to clear; writing 0 has no effect.
  - [9] BUSY, RO.
  - [15] RXLVL, RO; synchronised uart_rx.
  - Other bits read 0.
  - If a clear write and a TXDONE set occur in the same cycle, set wins.
- BAUD: full 16-bit RW.
- Write strobes: each strobe is independent; register updates on the edge where its strobe=1. Readbacks are registered, visible the cycle after the write.
- Baud source:
  - uart_baud_clk passes through a 2-flop synchroniser, then rising-edge detect, giving a 1-cycle pulse src_tick.
  - Bit period N = (BAUD+1) * (DIV_EN ? DIV_SEL : 1) src_ticks; prescaler and bit counter are 16+4 bits wide.
  - BAUD=0 with DIV_EN=0 gives 1 tick per bit.
  - BAUD and CON changes take effect at the next bit boundary.
- TXBUF write:
  - Accepted only when EN=1 and BUSY=0. The byte is stored and the frame starts: uart_tx=0 and BUSY=1 on the next edge. Tick counters reset at that edge.
  - Write while BUSY=1: ignored, TXBUF unchanged.
  - Write while EN=0: byte stored, no frame.
- TX FSM:
  - IDLE -> START: on accepted TXBUF write.
  - START -> DATA: after N ticks.
  - DATA: 8 bits, LSB first, N ticks each, then -> STOP.
  - STOP: line=1 for N ticks; at its end TXDONE=1, BUSY=0, -> IDLE.
  - Clearing EN mid-frame aborts: uart_tx=1, BUSY=0, TXDONE not set.
  - Back-to-back TXBUF write in the cycle after STOP ends is accepted.
- uart_int = TXDONE & TXIE, registered.

Decomposition:
- Shared package uart_pkg: CON bit-position localparams (EN, TXIE, DIV_EN, TXDONE, BUSY, RXLVL), DIV_SEL default, FSM state enum {IDLE, START, DATA, STOP}.
- One sub-module uart_baud_gen: synchroniser, edge detect, prescaler and bit-tick counter; outputs bit_tick, takes a restart input.
- Registers and FSM stay in the top module.

Test Plan:
- Reset: sys_rstn=0 for 30 cycles -> all readbacks 0, uart_tx=1, uart_int=0, uart_en=0.
- Register write/readback: BAUD=16'h0003, CON=16'h0011 -> uart_baud=3, uart_con=16'h0011 (plus RXLVL), uart_en=1.
- Frame timing: TXBUF=8'h6C with BAUD=3, DIV_EN=1 and a 24 MHz baud source on a 48 MHz sys_clk:
  - uart_tx bit sequence 0,0,0,1,1,0,1,1,0,1.
  - Each bit 12 src_ticks (500 ns); frame done within 15*4*3 baud-source cycles.
  - TXDONE=1, uart_int stays 0 (TXIE=0).
- Interrupt: same frame with CON=16'h0013 -> uart_int=1 after stop bit; write CON=16'h0113 -> TXDONE and uart_int clear.
- Busy guard: write TXBUF=8'hA5 during a frame -> ignored; uart_txbuf still 16'h006C, frame unaltered.
- Disable and abort:
  - EN=0 then TXBUF write -> uart_tx stays 1, byte stored.
  - EN cleared mid-frame -> uart_tx=1 next cycle, BUSY=0.
  - Reset mid-frame -> same idle state.
